// File: rtl/nbit_code_monitor.sv
// Decoder and sequence checker for n-bit Johnson, ring and Gray counter codes.
// Ports: clk, rst (sync active-low), in_valid, mode[1:0], code[N-1:0], err_clr
//        -> index[IW-1:0], index_valid, illegal, seq_err, locked, err_count[7:0].
module nbit_code_monitor #(
    parameter int N      = 4,
    parameter int IW     = 4,
    parameter int LOCK_N = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    mode,
    input  logic [N-1:0]  code,
    input  logic          err_clr,
    output logic [IW-1:0] index,
    output logic          index_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [7:0]    err_count
);

    localparam int MW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e        state_q;
    state_e        eff_state;
    logic [1:0]    mode_q;
    logic [IW-1:0] ref_q;
    logic [MW-1:0] match_q;
    logic [IW-1:0] index_q;
    logic          index_valid_q;
    logic          illegal_q;
    logic          seq_err_q;
    logic [7:0]    err_q;
    logic [7:0]    err_d;

    logic [IW-1:0] idx;
    logic [N-1:0]  gb;
    logic          legal;
    logic          succ;
    logic          inc;
    int            pop;
    int            trans;
    int            per;
    int            nxt;

    always_comb begin
        legal = 1'b0;
        idx   = '0;
        pop   = 0;
        trans = 0;
        per   = 1;
        gb    = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + int'(code[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            trans = trans + int'(code[i] ^ code[i+1]);
        end
        gb[N-1] = code[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            gb[i] = gb[i+1] ^ code[i];
        end
        unique case (mode)
            2'd0: begin
                per   = 2 * N;
                // Johnson codes are a single run boundary; the MSB tells
                // whether we are in the filling or the draining half.
                legal = (trans <= 1);
                if (code[N-1] || pop == 0) begin
                    idx = IW'(pop);
                end else begin
                    idx = IW'(2 * N - pop);
                end
            end
            2'd1: begin
                per   = N;
                legal = (pop == 1);
                for (int p = 0; p < N; p++) begin
                    if (code[p]) begin
                        idx = (p == 0) ? '0 : IW'(N - p);
                    end
                end
            end
            2'd2: begin
                per   = 1 << N;
                legal = 1'b1;
                idx   = IW'(gb);
            end
            default: begin
                per   = 1;
                legal = 1'b0;
            end
        endcase

        nxt = int'(ref_q) + 1;
        if (nxt >= per) begin
            nxt = 0;
        end
        succ = (int'(idx) == nxt);

        // A mode switch restarts acquisition on the switching sample.
        eff_state = (mode != mode_q) ? SEARCH : state_q;

        inc = in_valid && (!legal || (eff_state == LOCKED && !succ));

        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= SEARCH;
            mode_q        <= '0;
            ref_q         <= '0;
            match_q       <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_q         <= '0;
        end else begin
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_q         <= err_d;
            if (in_valid) begin
                mode_q <= mode;
                if (!legal) begin
                    illegal_q <= 1'b1;
                    state_q   <= SEARCH;
                    match_q   <= '0;
                end else begin
                    index_valid_q <= 1'b1;
                    index_q       <= idx;
                    ref_q         <= idx;
                    case (eff_state)
                        TRACK: begin
                            if (succ) begin
                                match_q <= match_q + MW'(1);
                                if (int'(match_q) + 1 >= LOCK_N) begin
                                    state_q <= LOCKED;
                                end
                            end else begin
                                match_q <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!succ) begin
                                seq_err_q <= 1'b1;
                                state_q   <= TRACK;
                                match_q   <= '0;
                            end
                        end
                        default: begin
                            match_q <= '0;
                            state_q <= TRACK;
                        end
                    endcase
                end
            end
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == LOCKED);
    assign err_count   = err_q;

endmodule

// File: tb/tb_nbit_code_monitor.sv
// Directed bench for nbit_code_monitor with an expected-result queue.
// Each step drives one cycle and compares the registered outputs after it.
module tb_nbit_code_monitor;

    typedef struct packed {
        logic [3:0] idx;
        logic       iv;
        logic       il;
        logic       se;
        logic       lk;
        logic [7:0] ec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] code = 4'd0;
    logic       err_clr = 1'b0;
    logic [3:0] index;
    logic       index_valid;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    nbit_code_monitor #(.N(4), .IW(4), .LOCK_N(2)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .mode(mode),
        .code(code),
        .err_clr(err_clr),
        .index(index),
        .index_valid(index_valid),
        .illegal(illegal),
        .seq_err(seq_err),
        .locked(locked),
        .err_count(err_count)
    );

    task automatic chk(input string tag, input int stp,
                       input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed=%0h expected=%0h",
                   tag, stp, got, exp);
        end
    endtask

    int stepno = 0;

    task automatic step(input logic r, input logic v,
                        input logic [1:0] m, input logic [3:0] c,
                        input logic clr, input logic [3:0] ei,
                        input logic eiv, input logic eil,
                        input logic ese, input logic elk,
                        input logic [7:0] eec);
        exp_t e;
        e = '{idx: ei, iv: eiv, il: eil, se: ese, lk: elk, ec: eec};
        @(negedge clk);
        rst = r;
        in_valid = v;
        mode = m;
        code = c;
        err_clr = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        stepno++;
        chk("index", stepno, 8'(index), 8'(e.idx));
        chk("index_valid", stepno, 8'(index_valid), 8'(e.iv));
        chk("illegal", stepno, 8'(illegal), 8'(e.il));
        chk("seq_err", stepno, 8'(seq_err), 8'(e.se));
        chk("locked", stepno, 8'(locked), 8'(e.lk));
        chk("err_count", stepno, err_count, e.ec);
    endtask

    initial begin
        // reset with random inputs
        repeat (2) begin
            step(1'b0, 1'($urandom()), 2'($urandom()), 4'($urandom()),
                 1'($urandom()), 4'd0, 0, 0, 0, 0, 8'd0);
        end
        // Johnson lock and wrap
        step(1, 1, 2'd0, 4'b0000, 0, 4'd0, 1, 0, 0, 0, 8'd0);
        step(1, 1, 2'd0, 4'b1000, 0, 4'd1, 1, 0, 0, 0, 8'd0);
        step(1, 1, 2'd0, 4'b1100, 0, 4'd2, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd0, 4'b1110, 0, 4'd3, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd0, 4'b1111, 0, 4'd4, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd0, 4'b0111, 0, 4'd5, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd0, 4'b0011, 0, 4'd6, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd0, 4'b0001, 0, 4'd7, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd0, 4'b0000, 0, 4'd0, 1, 0, 0, 1, 8'd0);
        step(1, 0, 2'd0, 4'b0101, 0, 4'd0, 0, 0, 0, 1, 8'd0);
        // mode change to ring while locked, then ring sequence
        step(1, 1, 2'd1, 4'b0001, 0, 4'd0, 1, 0, 0, 0, 8'd0);
        step(1, 1, 2'd1, 4'b1000, 0, 4'd1, 1, 0, 0, 0, 8'd0);
        step(1, 1, 2'd1, 4'b0100, 0, 4'd2, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd1, 4'b0010, 0, 4'd3, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd1, 4'b0001, 0, 4'd0, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd1, 4'b0011, 0, 4'd0, 0, 1, 0, 0, 8'd1);
        step(1, 1, 2'd1, 4'b0001, 0, 4'd0, 1, 0, 0, 0, 8'd1);
        step(1, 1, 2'd1, 4'b1000, 0, 4'd1, 1, 0, 0, 0, 8'd1);
        step(1, 1, 2'd1, 4'b0100, 0, 4'd2, 1, 0, 0, 1, 8'd1);
        // reset while locked
        step(0, 1, 2'd1, 4'b0010, 0, 4'd0, 0, 0, 0, 0, 8'd0);
        // Gray skip and relock
        step(1, 1, 2'd2, 4'b0000, 0, 4'd0, 1, 0, 0, 0, 8'd0);
        step(1, 1, 2'd2, 4'b0001, 0, 4'd1, 1, 0, 0, 0, 8'd0);
        step(1, 1, 2'd2, 4'b0011, 0, 4'd2, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd2, 4'b0010, 0, 4'd3, 1, 0, 0, 1, 8'd0);
        step(1, 1, 2'd2, 4'b0111, 0, 4'd5, 1, 0, 1, 0, 8'd1);
        step(1, 1, 2'd2, 4'b0101, 0, 4'd6, 1, 0, 0, 0, 8'd1);
        step(1, 1, 2'd2, 4'b0100, 0, 4'd7, 1, 0, 0, 1, 8'd1);
        step(1, 0, 2'd2, 4'b1111, 0, 4'd7, 0, 0, 0, 1, 8'd1);
        // illegal Johnson code on a mode switch
        step(1, 1, 2'd0, 4'b1001, 0, 4'd7, 0, 1, 0, 0, 8'd2);
        // error counter saturation and clear
        step(0, 0, 2'd0, 4'b0000, 0, 4'd0, 0, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 260; k++) begin
            step(1, 1, 2'd3, 4'($urandom()), 0, 4'd0, 0, 1, 0, 0,
                 8'((k > 255) ? 255 : k));
        end
        step(1, 1, 2'd3, 4'b0001, 1, 4'd0, 0, 1, 0, 0, 8'd0);
        step(1, 1, 2'd3, 4'b0001, 0, 4'd0, 0, 1, 0, 0, 8'd1);
        step(1, 0, 2'd3, 4'b0001, 1, 4'd0, 0, 0, 0, 0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
